// File: rtl/bird_pkg.sv
// Shared types and constants for the bird column game logic.
package bird_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } game_state_e;

    localparam int FALL_PERIOD_DEFAULT = 25_000_000;

endpackage

// File: rtl/key_edge.sv
// Button conditioner: 2-flop synchronizer plus previous-value flop; press is the
// single-cycle falling edge of the active-low key.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic sync_a;
    logic sync_b;
    logic prev;

    // All flops reset to released so no spurious press follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

    assign press = !sync_b && prev;

endmodule

// File: rtl/bird_motion_ctrl.sv
// Game state and motion pulses for the bird column: flap on button press,
// fall on each gravity step, and game over on crash or hitting the bottom.
module bird_motion_ctrl
    import bird_pkg::*;
#(
    parameter int FALL_PERIOD = FALL_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic at_top,
    input  logic at_bottom,
    input  logic crash,
    output logic flap,
    output logic fall,
    output logic playing,
    output logic dead
);

    localparam int CW = $clog2(FALL_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(FALL_PERIOD - 1);

    game_state_e   state;
    game_state_e   state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          flap_q;
    logic          flap_nxt;
    logic          press;
    logic          grav;

    key_edge u_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            flap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            flap_q <= flap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flap_nxt  = 1'b0;
        // A flap restarts the gravity period, so it also cancels a coinciding step.
        grav      = (state == S_PLAY) && (count == LAST) && !flap_q;
        fall      = grav && !at_bottom;
        case (state)
            S_IDLE: begin
                if (press) begin
                    state_nxt = S_PLAY;
                    count_nxt = '0;
                end
            end
            S_PLAY: begin
                flap_nxt  = press && !at_top;
                count_nxt = (flap_q || count == LAST) ? '0 : count + CW'(1);
                if (crash || (grav && at_bottom))
                    state_nxt = S_DEAD;
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    // flap_q is emitted unconditionally so a flap registered on the crash edge still shows.
    assign flap    = flap_q;
    assign playing = (state == S_PLAY);
    assign dead    = (state == S_DEAD);

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl (FALL_PERIOD=4) with a cycle-level
// behavioural model checked every cycle, plus hand-computed spot checks.
module tb_bird_motion_ctrl;

    localparam int FP = 4;

    logic clk = 1'b0;
    logic reset, key_n, at_top, at_bottom, crash;
    logic flap, fall, playing, dead;

    int tests = 0;
    int fails = 0;
    int t = 0;

    bird_motion_ctrl #(.FALL_PERIOD(FP)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .crash     (crash),
        .flap      (flap),
        .fall      (fall),
        .playing   (playing),
        .dead      (dead)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Model: game mode, key sample history, and gravity phase measured as
    // elapsed cycles since the last period restart (game start or flap).
    int mode   = 0;          // 0 idle, 1 playing, 2 dead
    bit m_flap = 1'b0;
    int anchor = 0;
    int mcyc   = 0;
    bit ks[3]  = '{1'b1, 1'b1, 1'b1};

    function automatic bit m_step_due();
        return (mode == 1) && (((mcyc - anchor) % FP) == FP - 1) && !m_flap;
    endfunction

    always @(posedge clk) begin
        bit pr, g;
        pr = !ks[1] && ks[2];           // falling edge seen two samples back
        g  = m_step_due();
        if (reset) begin
            mode   = 0;
            m_flap = 1'b0;
            ks     = '{1'b1, 1'b1, 1'b1};
        end else begin
            bit nf;
            nf = (mode == 1) && pr && !at_top;
            if (mode == 0 && pr) begin
                mode   = 1;
                anchor = mcyc + 1;
            end else if (mode == 1) begin
                if (m_flap) anchor = mcyc + 1;
                if (crash || (g && at_bottom)) mode = 2;
            end
            m_flap = nf;
            ks[2] = ks[1];
            ks[1] = ks[0];
            ks[0] = key_n;
        end
        mcyc++;
    end

    always @(negedge clk) begin
        chk("model_flap",    flap,    m_flap);
        chk("model_fall",    fall,    m_step_due() && !at_bottom);
        chk("model_playing", playing, mode == 1);
        chk("model_dead",    dead,    mode == 2);
    end

    task automatic tick();
        @(posedge clk);
        #2;
        t++;
    endtask

    initial begin
        int nfl, nfa, ft;
        reset = 1'b1; key_n = 1'b1; at_top = 1'b0; at_bottom = 1'b0; crash = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_flap", flap, 0);
        chk("rst_fall", fall, 0);
        chk("rst_playing", playing, 0);
        chk("rst_dead", dead, 0);

        nfl = 0; nfa = 0;
        repeat (20) begin
            tick();
            nfl += int'(flap);
            nfa += int'(fall);
        end
        chk("idle_flaps", nfl, 0);
        chk("idle_falls", nfa, 0);
        chk("idle_playing", playing, 0);

        key_n = 1'b0;
        tick(); tick();
        chk("start_early", playing, 0);
        tick();
        chk("start_playing", playing, 1);
        chk("start_noflap", flap, 0);
        key_n = 1'b1;
        t = 0;

        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("cadence_fall_t%0d", t), fall, (t % 4 == 3) ? 1 : 0);
        end

        // Long hold starting at t=13: one flap at t=16, gravity restarts.
        tick();
        key_n = 1'b0;
        nfl = 0; ft = -1;
        while (t < 22) begin
            tick();
            if (flap) begin nfl++; ft = t; end
            if (t == 15) chk("hold_fall_old_phase", fall, 1);
            if (t == 19) chk("hold_no_fall_old_phase", fall, 0);
            if (t == 20) chk("hold_fall_new_phase", fall, 1);
        end
        key_n = 1'b1;
        chk("hold_flap_count", nfl, 1);
        chk("hold_flap_cycle", ft, 16);

        // Flap coinciding with count==3 at t=32.
        while (t < 29) tick();
        key_n = 1'b0;
        while (t < 32) tick();
        chk("coinc_flap", flap, 1);
        chk("coinc_fall", fall, 0);
        key_n = 1'b1;

        // Press with at_top: ignored, cadence unchanged.
        tick();
        at_top = 1'b1; key_n = 1'b0;
        while (t < 36) tick();
        chk("top_noflap", flap, 0);
        chk("top_fall", fall, 1);
        at_top = 1'b0; key_n = 1'b1;
        while (t < 40) tick();
        chk("top_fall_next", fall, 1);

        // Bottom reached on the gravity step at t=44.
        tick();
        at_bottom = 1'b1;
        while (t < 44) tick();
        chk("bottom_nofall", fall, 0);
        chk("bottom_still_playing", playing, 1);
        tick();
        chk("bottom_dead", dead, 1);
        chk("bottom_playing", playing, 0);
        key_n = 1'b0;
        nfl = 0; nfa = 0;
        repeat (6) begin
            tick();
            nfl += int'(flap);
            nfa += int'(fall);
        end
        chk("dead_flaps", nfl, 0);
        chk("dead_falls", nfa, 0);
        key_n = 1'b1; at_bottom = 1'b0;

        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_dead", dead, 0);
        chk("rst2_playing", playing, 0);

        // New game, then crash on the same edge that registers a flap.
        repeat (3) tick();
        key_n = 1'b0;
        repeat (3) tick();
        chk("restart_playing", playing, 1);
        key_n = 1'b1;
        repeat (3) tick();
        key_n = 1'b0;
        repeat (2) tick();
        crash = 1'b1;
        tick();
        chk("crash_dead", dead, 1);
        chk("crash_playing", playing, 0);
        chk("crash_flap_once", flap, 1);
        crash = 1'b0; key_n = 1'b1;
        tick();
        chk("crash_flap_gone", flap, 0);
        chk("crash_sticky", dead, 1);

        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst3_flap", flap, 0);
        chk("rst3_fall", fall, 0);
        chk("rst3_playing", playing, 0);
        chk("rst3_dead", dead, 0);
        chk("rst3_count", int'(dut.count), 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
